// File: rtl/controllo_movimento_if.sv
// Signal bundle between the sprite motion controller and its driver:
// control/button inputs toward the controller, position and status back.
interface controllo_movimento_if;
  logic        ENABLE;
  logic        FRAME_TICK;
  logic        BTN_SU;
  logic        BTN_GIU;
  logic        BTN_SX;
  logic        BTN_DX;
  logic [10:0] X_POS;
  logic [10:0] Y_POS;
  logic        BUSY;
  logic        BORDO;

  modport master (
    output ENABLE, FRAME_TICK, BTN_SU, BTN_GIU, BTN_SX, BTN_DX,
    input  X_POS, Y_POS, BUSY, BORDO
  );

  modport slave (
    input  ENABLE, FRAME_TICK, BTN_SU, BTN_GIU, BTN_SX, BTN_DX,
    output X_POS, Y_POS, BUSY, BORDO
  );
endinterface

// File: rtl/controllo_movimento.sv
// Per-frame sprite motion controller: samples the buttons on FRAME_TICK, moves with
// accelerating step, wraps X modulo H, clamps Y to the visible area.
module controllo_movimento #(
  parameter int unsigned H           = 1280,
  parameter int unsigned V           = 1024,
  parameter int unsigned ALTEZZA     = 100,
  parameter int unsigned X_INIT      = 590,
  parameter int unsigned Y_INIT      = 462,
  parameter int unsigned PASSO_MIN   = 1,
  parameter int unsigned PASSO_MAX   = 8,
  parameter int unsigned FRAME_ACCEL = 4
) (
  input logic                  CLK,
  input logic                  RESET_N,
  controllo_movimento_if.slave bus
);

  localparam int unsigned STEP_W = $clog2(PASSO_MAX + 1);
  localparam int unsigned HOLD_W = $clog2(FRAME_ACCEL + 1);
  localparam logic [11:0] H12    = 12'(H);
  localparam logic [11:0] Y_MAX  = 12'(V - ALTEZZA);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} stato_t;

  stato_t state_q, state_d;

  // bit order everywhere: {su, giu, sx, dx}
  logic [3:0]        btn_meta, btn_sync, btn_lat;
  logic [10:0]       x_next_q, y_next_q;
  logic              clamp_q;
  logic [STEP_W-1:0] step_q;
  logic [HOLD_W-1:0] hold_q;

  logic [11:0] x12, y12, s12, x_calc, y_calc;
  logic        clamp_calc, moto;

  always_ff @(posedge CLK) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.FRAME_TICK && bus.ENABLE) state_d = CALC_X;
      CALC_X:  state_d = CALC_Y;
      CALC_Y:  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x12        = {1'b0, bus.X_POS};
    y12        = {1'b0, bus.Y_POS};
    s12        = 12'(step_q);
    x_calc     = x12;
    y_calc     = y12;
    clamp_calc = 1'b0;

    if (btn_lat[0] && !btn_lat[1]) begin
      x_calc = x12 + s12;
      if (x_calc >= H12) x_calc = x_calc - H12;
    end else if (btn_lat[1] && !btn_lat[0]) begin
      if (x12 < s12) x_calc = x12 + H12 - s12;
      else           x_calc = x12 - s12;
    end

    if (btn_lat[2] && !btn_lat[3]) begin
      y_calc = y12 + s12;
      if (y_calc > Y_MAX) begin
        y_calc     = Y_MAX;
        clamp_calc = 1'b1;
      end
    end else if (btn_lat[3] && !btn_lat[2]) begin
      if (y12 < s12) begin
        y_calc     = '0;
        clamp_calc = 1'b1;
      end else begin
        y_calc = y12 - s12;
      end
    end

    // a clamped move still counts as motion; opposing pairs cancel
    moto = (btn_lat[0] ^ btn_lat[1]) | (btn_lat[2] ^ btn_lat[3]);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      btn_meta  <= '0;
      btn_sync  <= '0;
      btn_lat   <= '0;
      x_next_q  <= 11'(X_INIT);
      y_next_q  <= 11'(Y_INIT);
      clamp_q   <= 1'b0;
      step_q    <= STEP_W'(PASSO_MIN);
      hold_q    <= '0;
      bus.X_POS <= 11'(X_INIT);
      bus.Y_POS <= 11'(Y_INIT);
      bus.BUSY  <= 1'b0;
      bus.BORDO <= 1'b0;
    end else begin
      btn_meta  <= {bus.BTN_SU, bus.BTN_GIU, bus.BTN_SX, bus.BTN_DX};
      btn_sync  <= btn_meta;
      bus.BORDO <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!bus.ENABLE) begin
            step_q <= STEP_W'(PASSO_MIN);
            hold_q <= '0;
          end else if (bus.FRAME_TICK) begin
            btn_lat  <= btn_sync;
            bus.BUSY <= 1'b1;
          end
        end
        CALC_X: x_next_q <= x_calc[10:0];
        CALC_Y: begin
          y_next_q <= y_calc[10:0];
          clamp_q  <= clamp_calc;
        end
        COMMIT: begin
          bus.X_POS <= x_next_q;
          bus.Y_POS <= y_next_q;
          bus.BORDO <= clamp_q;
          bus.BUSY  <= 1'b0;
          if (moto) begin
            if (hold_q + 1'b1 == HOLD_W'(FRAME_ACCEL)) begin
              hold_q <= '0;
              if (step_q != STEP_W'(PASSO_MAX)) step_q <= step_q + 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end else begin
            step_q <= STEP_W'(PASSO_MIN);
            hold_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controllo_movimento.sv
// Bench for controllo_movimento: directed scenarios and random frames checked
// against an arithmetic model of position, step and hold count.
module tb_controllo_movimento;

  localparam int HH   = 1280;
  localparam int YMAX = 1024 - 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  controllo_movimento_if bus ();

  controllo_movimento #(
    .H(1280), .V(1024), .ALTEZZA(100), .X_INIT(590), .Y_INIT(462),
    .PASSO_MIN(1), .PASSO_MAX(8), .FRAME_ACCEL(4)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int mx, my, mstep, mhold;
  bit mclamp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 590; my = 462; mstep = 1; mhold = 0; mclamp = 0;
  endtask

  task automatic model_frame(input bit su, input bit giu, input bit sx, input bit dx, input bit en);
    int hx, vy;
    mclamp = 0;
    if (!en) begin
      mstep = 1; mhold = 0;
      return;
    end
    hx = int'(dx) - int'(sx);
    vy = int'(giu) - int'(su);
    if (hx > 0) mx = (mx + mstep) % HH;
    if (hx < 0) mx = (mx - mstep + HH) % HH;
    if (vy > 0) begin
      if (my + mstep > YMAX) begin my = YMAX; mclamp = 1; end
      else my = my + mstep;
    end
    if (vy < 0) begin
      if (my < mstep) begin my = 0; mclamp = 1; end
      else my = my - mstep;
    end
    if (hx != 0 || vy != 0) begin
      mhold++;
      if (mhold == 4) begin
        mhold = 0;
        if (mstep < 8) mstep++;
      end
    end else begin
      mstep = 1; mhold = 0;
    end
  endtask

  task automatic set_in(input bit su, input bit giu, input bit sx, input bit dx, input bit en);
    bus.BTN_SU = su; bus.BTN_GIU = giu; bus.BTN_SX = sx; bus.BTN_DX = dx; bus.ENABLE = en;
  endtask

  // one full update: buttons settle through the synchronizer, tick, result after edge 3
  task automatic do_frame(input bit su, input bit giu, input bit sx, input bit dx, input bit en);
    @(negedge clk);
    set_in(su, giu, sx, dx, en);
    repeat (3) @(negedge clk);
    bus.FRAME_TICK = 1'b1;
    @(negedge clk);
    bus.FRAME_TICK = 1'b0;
    repeat (3) @(negedge clk);
    model_frame(su, giu, sx, dx, en);
    chk("frame_x", 32'(bus.X_POS), 32'(mx));
    chk("frame_y", 32'(bus.Y_POS), 32'(my));
    chk("frame_bordo", 32'(bus.BORDO), 32'(mclamp));
    chk("frame_busy", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic goto_x(input int target);
    int n = 0;
    while (mx != target && n < 600) begin
      if ((target - mx + HH) % HH >= mstep) do_frame(0, 0, 0, 1, 1);
      else                                  do_frame(0, 0, 0, 0, 1);
      n++;
    end
    chk("goto_x_reached", 32'(mx), 32'(target));
  endtask

  task automatic goto_y(input int target);
    int n = 0;
    while (my != target && n < 600) begin
      if (my < target) begin
        if (target - my >= mstep) do_frame(0, 1, 0, 0, 1);
        else                      do_frame(0, 0, 0, 0, 1);
      end else begin
        if (my - target >= mstep) do_frame(1, 0, 0, 0, 1);
        else                      do_frame(0, 0, 0, 0, 1);
      end
      n++;
    end
    chk("goto_y_reached", 32'(my), 32'(target));
  endtask

  initial begin
    int accel_exp[8];
    int y_before;
    accel_exp = '{1, 2, 3, 4, 6, 8, 10, 12};

    // reset
    rst_n = 1'b0;
    bus.FRAME_TICK = 1'b0;
    set_in(0, 0, 0, 0, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_x", 32'(bus.X_POS), 32'd590);
    chk("rst_y", 32'(bus.Y_POS), 32'd462);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_bordo", 32'(bus.BORDO), 32'd0);

    // wrap right
    goto_x(1278);
    do_frame(0, 0, 0, 0, 1);
    do_frame(0, 0, 0, 1, 1);
    chk("wrap_r_1279", 32'(bus.X_POS), 32'd1279);
    do_frame(0, 0, 0, 1, 1);
    chk("wrap_r_0", 32'(bus.X_POS), 32'd0);
    chk("wrap_r_bordo", 32'(bus.BORDO), 32'd0);

    // wrap left
    do_frame(0, 0, 0, 0, 1);
    y_before = my;
    do_frame(0, 0, 1, 0, 1);
    chk("wrap_l_1279", 32'(bus.X_POS), 32'd1279);
    chk("wrap_l_y", 32'(bus.Y_POS), 32'(y_before));

    // clamp at bottom after reaching step 4
    goto_y(898);
    do_frame(0, 0, 0, 0, 1);
    repeat (12) do_frame(0, 1, 0, 0, 1);
    chk("clamp_pre_y", 32'(bus.Y_POS), 32'd922);
    do_frame(0, 1, 0, 0, 1);
    chk("clamp_y", 32'(bus.Y_POS), 32'd924);
    chk("clamp_bordo_hi", 32'(bus.BORDO), 32'd1);
    @(negedge clk);
    chk("clamp_bordo_lo", 32'(bus.BORDO), 32'd0);

    // acceleration
    goto_x(0);
    do_frame(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      do_frame(0, 0, 0, 1, 1);
      chk("accel_x", 32'(bus.X_POS), 32'(accel_exp[i]));
    end
    do_frame(0, 0, 0, 0, 1);
    chk("release_x", 32'(bus.X_POS), 32'd12);
    do_frame(0, 0, 0, 1, 1);
    chk("release_step1", 32'(bus.X_POS), 32'd13);

    // timing: busy window, change at edge 3 only, second tick ignored
    @(negedge clk);
    set_in(0, 0, 0, 1, 1);
    repeat (3) @(negedge clk);
    bus.FRAME_TICK = 1'b1;
    @(negedge clk);
    chk("t_e0_busy", 32'(bus.BUSY), 32'd1);
    chk("t_e0_x", 32'(bus.X_POS), 32'd13);
    @(negedge clk);
    bus.FRAME_TICK = 1'b0;
    chk("t_e1_busy", 32'(bus.BUSY), 32'd1);
    chk("t_e1_x", 32'(bus.X_POS), 32'd13);
    @(negedge clk);
    chk("t_e2_busy", 32'(bus.BUSY), 32'd1);
    chk("t_e2_x", 32'(bus.X_POS), 32'd13);
    @(negedge clk);
    model_frame(0, 0, 0, 1, 1);
    chk("t_e3_busy", 32'(bus.BUSY), 32'd0);
    chk("t_e3_x", 32'(bus.X_POS), 32'd14);
    repeat (6) @(negedge clk);
    chk("t_no_queue_x", 32'(bus.X_POS), 32'd14);
    chk("t_no_queue_busy", 32'(bus.BUSY), 32'd0);

    // reset during an update discards it
    bus.FRAME_TICK = 1'b1;
    @(negedge clk);
    bus.FRAME_TICK = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("abort_x", 32'(bus.X_POS), 32'd590);
    chk("abort_y", 32'(bus.Y_POS), 32'd462);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    @(negedge clk);
    chk("abort_no_commit_x", 32'(bus.X_POS), 32'd590);
    chk("abort_no_commit_bordo", 32'(bus.BORDO), 32'd0);
    do_frame(0, 0, 0, 1, 1);
    chk("abort_step1", 32'(bus.X_POS), 32'd591);

    // disabled frame: no move, step back to minimum
    repeat (5) do_frame(0, 0, 0, 1, 1);
    do_frame(0, 0, 0, 1, 0);

    // random frames
    for (int i = 0; i < 200; i++) begin
      logic [3:0] b;
      b = 4'($urandom);
      if ($urandom_range(0, 2) != 0) b[1:0] = 2'b10;
      do_frame(b[3], b[2], b[1], b[0], $urandom_range(0, 9) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
